// File: rtl/recon_pkg.sv
// Shared constants and state encoding for the shift-add dividend reconstructor.
package recon_pkg;

    localparam int RECON_WIDTH = 8;
    localparam int RECON_CNT_W = $clog2(RECON_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/recon_step.sv
// One conditional shift-add iteration: adds B << shamt to the accumulator when qbit is set.
module recon_step
    import recon_pkg::*;
#(
    parameter int WIDTH = RECON_WIDTH,
    parameter int CNT_W = RECON_CNT_W
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   b,
    input  logic [CNT_W-1:0]   shamt,
    input  logic               qbit,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [2*WIDTH-1:0] addend;

    always_comb begin
        addend   = {{WIDTH{1'b0}}, b} << shamt;
        acc_next = qbit ? acc + addend : acc;
    end

endmodule

// File: rtl/shift_add_reconstructor.sv
// Rebuilds a dividend P = Q*B + R with one multiplier bit per clock, flagging invalid triples.
module shift_add_reconstructor
    import recon_pkg::*;
#(
    parameter int WIDTH = RECON_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   Q,
    input  logic [WIDTH-1:0]   B,
    input  logic [WIDTH-1:0]   R,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P,
    output logic               b_zero,
    output logic               rem_err
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   q_sh;
    logic [WIDTH-1:0]   b_lat;
    logic [WIDTH-1:0]   r_lat;

    // q_sh is shifted right each step so its LSB is always the current multiplier bit
    recon_step #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_step (
        .acc      (acc),
        .b        (b_lat),
        .shamt    (cnt),
        .qbit     (q_sh[0]),
        .acc_next (acc_next)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            q_sh    <= '0;
            b_lat   <= '0;
            r_lat   <= '0;
            P       <= '0;
            done    <= 1'b0;
            b_zero  <= 1'b0;
            rem_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        q_sh  <= Q;
                        b_lat <= B;
                        r_lat <= R;
                        acc   <= {{WIDTH{1'b0}}, R};
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc  <= acc_next;
                    q_sh <= q_sh >> 1;
                    cnt  <= cnt + CNT_W'(1);
                    // Last multiplier bit: publish the result and flags together
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        P       <= acc_next;
                        b_zero  <= (b_lat == '0);
                        rem_err <= (r_lat >= b_lat);
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/shift_add_reconstructor.md
SHIFT_ADD_RECONSTRUCTOR -- requirements
Module: shift_add_reconstructor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width (quotient, divisor, remainder); product is 2*WIDTH bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port Q  input  WIDTH  quotient operand.
REQ-006 SHALL have port B  input  WIDTH  divisor operand.
REQ-007 SHALL have port R  input  WIDTH  remainder operand.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-009 SHALL have port done  output  1  single-cycle pulse; P and flags valid.
REQ-010 SHALL have port P  output  2*WIDTH  reconstructed dividend, P = Q*B + R.
REQ-011 SHALL have port b_zero  output  1  captured B was zero.
REQ-012 SHALL have port rem_err  output  1  captured R >= B (triple not a valid division result).

Function
REQ-013 SHALL implement states IDLE, RUN and DONE.
REQ-014 IDLE with start=1 at edge k: SHALL latch Q, B and R, clear the accumulator to R zero-extended and the bit counter to 0, and enter RUN.
REQ-015 RUN: each edge SHALL examine one multiplier bit of latched Q (LSB first), add B shifted left by the counter into the 2*WIDTH accumulator when that bit is 1, and increment the counter.
REQ-016 RUN SHALL last exactly WIDTH edges (k+1..k+WIDTH); at edge k+WIDTH P SHALL be written from the final accumulator and state SHALL become DONE.
REQ-017 done SHALL be 1 only in DONE, i.e. for exactly one cycle, WIDTH cycles after the start-sampling edge; DONE SHALL return to IDLE on the next edge unconditionally.
REQ-018 P, b_zero and rem_err SHALL be updated only at the RUN->DONE edge and SHALL hold until the next completion.
REQ-019 start while busy=1 SHALL be ignored; operand changes after edge k SHALL not affect the result.
REQ-020 Arithmetic SHALL be unsigned and exact in 2*WIDTH bits; no overflow is possible (max (2^W-1)^2 + 2^W-1 < 2^(2W)).
REQ-021 B=0 SHALL produce P=R and b_zero=1; rem_err SHALL then also be 1.
REQ-022 busy SHALL be combinationally equal to (state != IDLE).

Reset
REQ-023 rst_n=0 SHALL asynchronously force IDLE, counter 0, accumulator 0, P=0, busy=0, done=0, b_zero=0, rem_err=0.
REQ-024 Reset asserted mid-RUN SHALL abort the operation with no done pulse; first start after deassertion SHALL behave as from power-up.

Structure
REQ-025 A shared package recon_pkg SHALL hold the WIDTH default, the state enumeration and the counter width constant ($clog2(WIDTH)+1).
REQ-026 One sub-module, recon_step, SHALL implement the single conditional shift-add iteration combinationally; the FSM, counter and registers SHALL live in the top module.

Verification
REQ-027 Q=0x0C, B=0x0A, R=0x05, start pulse -> done exactly 8 cycles later, P=0x007D, b_zero=0, rem_err=0.
REQ-028 Q=0xFF, B=0xFF, R=0xFE -> P=0xFEFF, flags 0; Q=0x00, B=0x37, R=0x12 -> P=0x0012.
REQ-029 Q=0x05, B=0x00, R=0x03 -> P=0x0003, b_zero=1, rem_err=1; Q=0x03, B=0x04, R=0x04 -> P=0x0010, rem_err=1.
REQ-030 start re-asserted with different operands during RUN -> ignored, original result delivered, busy stays high through DONE.
REQ-031 rst_n pulsed low at RUN cycle 4 -> outputs zero immediately, no done; new start Q=0x02, B=0x03, R=0x01 -> P=0x0007.
REQ-032 Random sweep of valid triples (R<B, B!=0) with back-to-back starts -> every P equals Q*B+R, exactly one done per accepted start.
